dpll_controller: RTL and testbench

Top-level search sequencer for the hardware SAT solver. Drives the DPLL loop: initial propagation, decision, BCP and backtrack. It hands work to the decision engine, the BCP engine and the backtrack engine through request/done handshakes. It also tracks the current decision level and reports the final SAT/UNSAT verdict plus search statistics.

---
 rtl/dpll_pkg.sv | 25 ++
 rtl/sat_counter.sv | 36 +++
 rtl/dpll_controller.sv | 138 +++++++++++++
 tb/tb_dpll_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared types and default sizing for the DPLL search sequencer.
package dpll_pkg;

  localparam int VAR_NUM_DEF = 8;
  localparam int VAR_W_DEF   = $clog2(VAR_NUM_DEF);
  localparam int LVL_W_DEF   = $clog2(VAR_NUM_DEF + 1);
  localparam int STAT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BCP       = 3'd1,
    ST_WAIT_BCP  = 3'd2,
    ST_CHECK     = 3'd3,
    ST_DECIDE    = 3'd4,
    ST_BACKTRACK = 3'd5,
    ST_SAT       = 3'd6,
    ST_UNSAT     = 3'd7
  } dpll_state_t;

  // A new search may only be launched from a resting state.
  function automatic logic accepts_start(input dpll_state_t s);
    return (s == ST_IDLE) || (s == ST_SAT) || (s == ST_UNSAT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dpll_controller.sv
// DPLL search sequencer: propagate, check, decide, backtrack; reports verdict and statistics.
module dpll_controller
  import dpll_pkg::*;
#(
  parameter int VAR_NUM = VAR_NUM_DEF,
  parameter int STAT_W  = STAT_W_DEF,
  parameter int VAR_W   = $clog2(VAR_NUM),
  parameter int LVL_W   = $clog2(VAR_NUM + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              free_any_i,
  output logic              decision_en_o,
  input  logic              decision_done_i,
  input  logic [VAR_W-1:0]  decision_var_i,
  output logic              bcp_start_o,
  input  logic              bcp_done_i,
  input  logic              bcp_conflict_i,
  output logic              back_sign_o,
  input  logic              back_done_i,
  output logic [LVL_W-1:0]  level_o,
  output logic [VAR_W-1:0]  last_var_o,
  output logic              busy_o,
  output logic              sat_o,
  output logic              unsat_o,
  output logic              error_o,
  output logic [STAT_W-1:0] n_decisions_o,
  output logic [STAT_W-1:0] n_conflicts_o
);

  dpll_state_t      state_q;
  dpll_state_t      state_d;
  logic [LVL_W-1:0] level_q;
  logic [VAR_W-1:0] last_var_q;
  logic             error_q;

  // Handshake events, each qualified by the state that is waiting for it.
  logic start_acc;
  logic dec_fire;
  logic lvl_full;
  logic dec_ok;
  logic dec_ovf;
  logic conf_top;
  logic bt_done;

  assign start_acc = start_i && accepts_start(state_q);
  assign dec_fire  = (state_q == ST_DECIDE) && decision_done_i;
  assign lvl_full  = (level_q == LVL_W'(VAR_NUM));
  assign dec_ok    = dec_fire && !lvl_full;
  assign dec_ovf   = dec_fire && lvl_full;
  assign conf_top  = (state_q == ST_WAIT_BCP) && bcp_done_i && bcp_conflict_i
                     && (level_q == '0);
  assign bt_done   = (state_q == ST_BACKTRACK) && back_done_i;

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the search loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_SAT, ST_UNSAT: if (start_i) state_d = ST_BCP;
      ST_BCP:                    state_d = ST_WAIT_BCP;
      ST_WAIT_BCP: begin
        if (bcp_done_i) begin
          if (!bcp_conflict_i)     state_d = ST_CHECK;
          else if (level_q == '0)  state_d = ST_UNSAT;
          else                     state_d = ST_BACKTRACK;
        end
      end
      ST_CHECK:                  state_d = free_any_i ? ST_DECIDE : ST_SAT;
      ST_DECIDE:    if (decision_done_i) state_d = lvl_full ? ST_UNSAT : ST_BCP;
      ST_BACKTRACK: if (back_done_i)     state_d = ST_BCP;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    bcp_start_o   = (state_q == ST_BCP);
    decision_en_o = (state_q == ST_DECIDE);
    back_sign_o   = (state_q == ST_BACKTRACK);
    sat_o         = (state_q == ST_SAT);
    unsat_o       = (state_q == ST_UNSAT);
    busy_o        = (state_q == ST_BCP) || (state_q == ST_WAIT_BCP) ||
                    (state_q == ST_CHECK) || (state_q == ST_DECIDE) ||
                    (state_q == ST_BACKTRACK);
  end

  // Decision level, last decided variable and overflow flag.
  // Backtrack is only entered with level > 0, so the decrement cannot underflow.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      level_q    <= '0;
      last_var_q <= '0;
      error_q    <= 1'b0;
    end else if (start_acc) begin
      level_q    <= '0;
      error_q    <= 1'b0;
    end else if (dec_ok) begin
      level_q    <= level_q + 1'b1;
      last_var_q <= decision_var_i;
    end else if (dec_ovf) begin
      error_q    <= 1'b1;
    end else if (bt_done) begin
      level_q    <= level_q - 1'b1;
    end
  end

  assign level_o    = level_q;
  assign last_var_o = last_var_q;
  assign error_o    = error_q;

  sat_counter #(.W(STAT_W)) u_dec_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clr_i   (start_acc),
    .inc_i   (dec_ok),
    .count_o (n_decisions_o)
  );

  // A conflict counts either when it ends the search at level 0 or when its backtrack completes.
  sat_counter #(.W(STAT_W)) u_conf_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clr_i   (start_acc),
    .inc_i   (conf_top || bt_done),
    .count_o (n_conflicts_o)
  );

endmodule

// File: tb/tb_dpll_controller.sv
// Directed table-driven bench for dpll_controller, plus a narrow-counter instance for saturation.
module tb_dpll_controller;

  logic        clock;
  logic        reset;
  logic        start;
  logic        free_any;
  logic        decision_done;
  logic [2:0]  decision_var;
  logic        bcp_done;
  logic        bcp_conflict;
  logic        back_done;

  logic        decision_en, bcp_start, back_sign;
  logic [3:0]  level;
  logic [2:0]  last_var;
  logic        busy, sat, unsat, error;
  logic [15:0] n_decisions, n_conflicts;

  logic        s_decision_en, s_bcp_start, s_back_sign;
  logic [3:0]  s_level;
  logic [2:0]  s_last_var;
  logic        s_busy, s_sat, s_unsat, s_error;
  logic [1:0]  s_n_decisions, s_n_conflicts;

  int n_total = 0;
  int n_pass  = 0;

  dpll_controller #(.VAR_NUM(8), .STAT_W(16)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .free_any_i(free_any),
    .decision_en_o(decision_en), .decision_done_i(decision_done),
    .decision_var_i(decision_var), .bcp_start_o(bcp_start), .bcp_done_i(bcp_done),
    .bcp_conflict_i(bcp_conflict), .back_sign_o(back_sign), .back_done_i(back_done),
    .level_o(level), .last_var_o(last_var), .busy_o(busy), .sat_o(sat),
    .unsat_o(unsat), .error_o(error), .n_decisions_o(n_decisions),
    .n_conflicts_o(n_conflicts)
  );

  dpll_controller #(.VAR_NUM(8), .STAT_W(2)) dut_small (
    .clock_i(clock), .reset_i(reset), .start_i(start), .free_any_i(free_any),
    .decision_en_o(s_decision_en), .decision_done_i(decision_done),
    .decision_var_i(decision_var), .bcp_start_o(s_bcp_start), .bcp_done_i(bcp_done),
    .bcp_conflict_i(bcp_conflict), .back_sign_o(s_back_sign), .back_done_i(back_done),
    .level_o(s_level), .last_var_o(s_last_var), .busy_o(s_busy), .sat_o(s_sat),
    .unsat_o(s_unsat), .error_o(s_error), .n_decisions_o(s_n_decisions),
    .n_conflicts_o(s_n_conflicts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Input bits: {reset, start, free_any, decision_done, bcp_done, bcp_conflict, back_done}
  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_RST   = 7'b1000000;
  localparam logic [6:0] I_START = 7'b0100000;
  localparam logic [6:0] I_FREE  = 7'b0010000;
  localparam logic [6:0] I_DD    = 7'b0001000;
  localparam logic [6:0] I_BD    = 7'b0000100;
  localparam logic [6:0] I_BDC   = 7'b0000110;
  localparam logic [6:0] I_BACK  = 7'b0000001;
  // Output flags: {bcp_start, decision_en, back_sign, busy, sat, unsat, error}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_BCP   = 7'b1001000;
  localparam logic [6:0] O_WAIT  = 7'b0001000;
  localparam logic [6:0] O_CHK   = 7'b0001000;
  localparam logic [6:0] O_DEC   = 7'b0101000;
  localparam logic [6:0] O_BT    = 7'b0011000;
  localparam logic [6:0] O_SAT   = 7'b0000100;
  localparam logic [6:0] O_UNS   = 7'b0000010;
  localparam logic [6:0] O_ERR   = 7'b0000011;

  typedef struct {
    logic [6:0]  ins;
    logic [2:0]  dv;
    logic [6:0]  outs;
    logic [3:0]  lvl;
    logic [2:0]  lv;
    logic [15:0] nd;
    logic [15:0] nc;
  } vec_t;

  localparam int NVEC = 45;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic [6:0] i, input int dv, input logic [6:0] o,
                              input int lvl, input int lv, input int nd, input int nc);
    vec_t v;
    v.ins  = i;
    v.dv   = 3'(dv);
    v.outs = o;
    v.lvl  = 4'(lvl);
    v.lv   = 3'(lv);
    v.nd   = 16'(nd);
    v.nc   = 16'(nc);
    return v;
  endfunction

  // Drive one cycle of inputs, then compare every main-DUT output just after the edge.
  task automatic apply(input vec_t v, input string nm);
    logic [6:0] got;
    {reset, start, free_any, decision_done, bcp_done, bcp_conflict, back_done} = v.ins;
    decision_var = v.dv;
    @(posedge clock);
    #1;
    got = {bcp_start, decision_en, back_sign, busy, sat, unsat, error};
    n_total++;
    if (got !== v.outs || level !== v.lvl || last_var !== v.lv ||
        n_decisions !== v.nd || n_conflicts !== v.nc) begin
      $display("FAIL %s: got flags=%b lvl=%0d last=%0d nd=%0d nc=%0d, expected flags=%b lvl=%0d last=%0d nd=%0d nc=%0d",
               nm, got, level, last_var, n_decisions, n_conflicts,
               v.outs, v.lvl, v.lv, v.nd, v.nc);
    end else begin
      n_pass++;
      $display("ok %s: flags=%b lvl=%0d last=%0d nd=%0d nc=%0d",
               nm, got, level, last_var, n_decisions, n_conflicts);
    end
  endtask

  task automatic check_small(input logic [1:0] exp_nd, input logic [1:0] exp_nc,
                             input logic exp_err, input string nm);
    n_total++;
    if (s_n_decisions !== exp_nd || s_n_conflicts !== exp_nc || s_error !== exp_err) begin
      $display("FAIL %s: got nd=%0d nc=%0d err=%b, expected nd=%0d nc=%0d err=%b",
               nm, s_n_decisions, s_n_conflicts, s_error, exp_nd, exp_nc, exp_err);
    end else begin
      n_pass++;
      $display("ok %s: nd=%0d nc=%0d err=%b", nm, s_n_decisions, s_n_conflicts, s_error);
    end
  endtask

  initial begin
    {reset, start, free_any, decision_done, bcp_done, bcp_conflict, back_done} = I_RST;
    decision_var = '0;

    // Conflict at level 2 with two backtracks, level-0 UNSAT, then three decisions to SAT,
    // then an immediate SAT. Stray handshakes outside their waiting states are mixed in.
    tbl[0]  = mk(I_RST,        0, O_IDLE, 0, 0, 0, 0);
    tbl[1]  = mk(I_START,      0, O_BCP,  0, 0, 0, 0);
    tbl[2]  = mk(I_NONE,       0, O_WAIT, 0, 0, 0, 0);
    tbl[3]  = mk(I_BD,         0, O_CHK,  0, 0, 0, 0);
    tbl[4]  = mk(I_FREE,       0, O_DEC,  0, 0, 0, 0);
    tbl[5]  = mk(I_DD,         5, O_BCP,  1, 5, 1, 0);
    tbl[6]  = mk(I_NONE,       0, O_WAIT, 1, 5, 1, 0);
    tbl[7]  = mk(I_BD,         0, O_CHK,  1, 5, 1, 0);
    tbl[8]  = mk(I_FREE,       0, O_DEC,  1, 5, 1, 0);
    tbl[9]  = mk(I_DD,         2, O_BCP,  2, 2, 2, 0);
    tbl[10] = mk(I_NONE,       0, O_WAIT, 2, 2, 2, 0);
    tbl[11] = mk(I_BDC,        0, O_BT,   2, 2, 2, 0);
    tbl[12] = mk(I_NONE,       0, O_BT,   2, 2, 2, 0);
    tbl[13] = mk(I_BDC | I_DD, 6, O_BT,   2, 2, 2, 0);
    tbl[14] = mk(I_BACK,       0, O_BCP,  1, 2, 2, 1);
    tbl[15] = mk(I_NONE,       0, O_WAIT, 1, 2, 2, 1);
    tbl[16] = mk(I_BDC,        0, O_BT,   1, 2, 2, 1);
    tbl[17] = mk(I_BACK,       0, O_BCP,  0, 2, 2, 2);
    tbl[18] = mk(I_NONE,       0, O_WAIT, 0, 2, 2, 2);
    tbl[19] = mk(I_BDC,        0, O_UNS,  0, 2, 2, 3);
    tbl[20] = mk(I_NONE,       0, O_UNS,  0, 2, 2, 3);
    tbl[21] = mk(I_BACK,       0, O_UNS,  0, 2, 2, 3);
    tbl[22] = mk(I_START,      0, O_BCP,  0, 2, 0, 0);
    tbl[23] = mk(I_NONE,       0, O_WAIT, 0, 2, 0, 0);
    tbl[24] = mk(I_BD,         0, O_CHK,  0, 2, 0, 0);
    tbl[25] = mk(I_FREE,       0, O_DEC,  0, 2, 0, 0);
    tbl[26] = mk(I_DD,         5, O_BCP,  1, 5, 1, 0);
    tbl[27] = mk(I_NONE,       0, O_WAIT, 1, 5, 1, 0);
    tbl[28] = mk(I_BD,         0, O_CHK,  1, 5, 1, 0);
    tbl[29] = mk(I_FREE,       0, O_DEC,  1, 5, 1, 0);
    tbl[30] = mk(I_DD,         2, O_BCP,  2, 2, 2, 0);
    tbl[31] = mk(I_NONE,       0, O_WAIT, 2, 2, 2, 0);
    tbl[32] = mk(I_BD,         0, O_CHK,  2, 2, 2, 0);
    tbl[33] = mk(I_FREE,       0, O_DEC,  2, 2, 2, 0);
    tbl[34] = mk(I_BD,         0, O_DEC,  2, 2, 2, 0);
    tbl[35] = mk(I_DD,         7, O_BCP,  3, 7, 3, 0);
    tbl[36] = mk(I_NONE,       0, O_WAIT, 3, 7, 3, 0);
    tbl[37] = mk(I_BD,         0, O_CHK,  3, 7, 3, 0);
    tbl[38] = mk(I_NONE,       0, O_SAT,  3, 7, 3, 0);
    tbl[39] = mk(I_NONE,       0, O_SAT,  3, 7, 3, 0);
    tbl[40] = mk(I_BD | I_BACK, 0, O_SAT, 3, 7, 3, 0);
    tbl[41] = mk(I_START,      0, O_BCP,  0, 7, 0, 0);
    tbl[42] = mk(I_START,      0, O_WAIT, 0, 7, 0, 0);
    tbl[43] = mk(I_BD,         0, O_CHK,  0, 7, 0, 0);
    tbl[44] = mk(I_NONE,       0, O_SAT,  0, 7, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the fourth cycle of a held decision request, together with start and decision_done.
    apply(mk(I_RST,   0, O_IDLE, 0, 0, 0, 0), "rd_reset");
    apply(mk(I_START, 0, O_BCP,  0, 0, 0, 0), "rd_start");
    apply(mk(I_NONE,  0, O_WAIT, 0, 0, 0, 0), "rd_wait0");
    apply(mk(I_BD,    0, O_CHK,  0, 0, 0, 0), "rd_chk0");
    apply(mk(I_FREE,  0, O_DEC,  0, 0, 0, 0), "rd_dec0");
    apply(mk(I_DD,    3, O_BCP,  1, 3, 1, 0), "rd_bcp1");
    apply(mk(I_NONE,  0, O_WAIT, 1, 3, 1, 0), "rd_wait1");
    apply(mk(I_BD,    0, O_CHK,  1, 3, 1, 0), "rd_chk1");
    apply(mk(I_FREE,  0, O_DEC,  1, 3, 1, 0), "rd_dec_c1");
    apply(mk(I_NONE,  0, O_DEC,  1, 3, 1, 0), "rd_dec_c2");
    apply(mk(I_NONE,  0, O_DEC,  1, 3, 1, 0), "rd_dec_c3");
    apply(mk(I_NONE,  0, O_DEC,  1, 3, 1, 0), "rd_dec_c4");
    apply(mk(I_RST | I_START | I_DD, 4, O_IDLE, 0, 0, 0, 0), "rd_reset_mid");
    apply(mk(I_DD,    4, O_IDLE, 0, 0, 0, 0), "rd_late_done");

    // Nine back-to-back decisions: the ninth overflows the level bound.
    apply(mk(I_START, 0, O_BCP, 0, 0, 0, 0), "ov_start");
    for (int k = 0; k < 9; k++) begin
      int lv_exp;
      lv_exp = (k == 0) ? 0 : k - 1;
      apply(mk(I_NONE, 0, O_WAIT, k, lv_exp, k, 0), $sformatf("ov_wait%0d", k));
      apply(mk(I_BD,   0, O_CHK,  k, lv_exp, k, 0), $sformatf("ov_chk%0d", k));
      apply(mk(I_FREE, 0, O_DEC,  k, lv_exp, k, 0), $sformatf("ov_dec%0d", k));
      if (k < 8) begin
        apply(mk(I_DD, k, O_BCP, k + 1, k, k + 1, 0), $sformatf("ov_done%0d", k));
      end else begin
        apply(mk(I_DD, 0, O_ERR, 8, 7, 8, 0), "ov_overflow");
      end
      if (k == 4) check_small(2'd3, 2'd0, 1'b0, "sat_after5");
    end
    check_small(2'd3, 2'd0, 1'b1, "sat_after_ovf");
    apply(mk(I_NONE,  0, O_ERR, 8, 7, 8, 0), "ov_sticky");
    apply(mk(I_START, 0, O_BCP, 0, 7, 0, 0), "ov_restart");
    check_small(2'd0, 2'd0, 1'b0, "sat_cleared");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
